// File: rtl/aplic_pkg.sv
// APLIC shared types: source-mode encoding and per-mode helper functions.
// Latency: n/a (types and combinational helpers only).
// Backpressure: n/a.
package aplic_pkg;

   localparam int SM_W = 3;

   // sourcecfg.SM encoding; RSV2/RSV3 behave like INACTIVE.
   typedef enum logic [SM_W-1:0] {
      INACTIVE = 3'd0,
      DETACHED = 3'd1,
      RSV2     = 3'd2,
      RSV3     = 3'd3,
      EDGE1    = 3'd4,
      EDGE0    = 3'd5,
      LEVEL1   = 3'd6,
      LEVEL0   = 3'd7
   } sm_e;

   function automatic logic is_edge(sm_e sm);
      return (sm == EDGE1) || (sm == EDGE0);
   endfunction

   function automatic logic is_level(sm_e sm);
      return (sm == LEVEL1) || (sm == LEVEL0);
   endfunction

   // Map the sampled wire to "interrupt asserted" for the given mode.
   function automatic logic rectify(sm_e sm, logic s);
      case (sm)
         EDGE1, LEVEL1: return s;
         EDGE0, LEVEL0: return ~s;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/aplic_gateway_if.sv
// Gateway bus bundle: raw sources, modes and pending bits in; set/clr requests and rectified value out.
// Latency: n/a (wiring only).
// Backpressure: none; requests are one-cycle pulses with no handshake.
// Ports: slave = gateway side, master = pending-register-file / driver side.
interface aplic_gateway_if
   import aplic_pkg::*;
#(
   parameter int NR_SRC = 32
);
   logic [NR_SRC-1:0]      irq_src_i;
   logic [SM_W*NR_SRC-1:0] sm_i;
   logic [NR_SRC-1:0]      ip_i;
   logic [NR_SRC-1:0]      set_ip_o;
   logic [NR_SRC-1:0]      clr_ip_o;
   logic [NR_SRC-1:0]      rectified_o;

   modport slave (
      input  irq_src_i, sm_i, ip_i,
      output set_ip_o, clr_ip_o, rectified_o
   );

   modport master (
      output irq_src_i, sm_i, ip_i,
      input  set_ip_o, clr_ip_o, rectified_o
   );
endinterface

// File: rtl/aplic_gw_slice.sv
// One interrupt source: optional 2-flop sync, rectify, edge/level request generation.
// Latency: 1 cycle input->output (3 cycles with AIA_GW_SYNC_EN defined).
// Backpressure: none; level requests repeat every cycle until ip_i reflects them.
// Ports: clk_i/rst_ni; irq_src_i raw wire; sm_i mode; ip_i current pending bit;
//        set_ip_o/clr_ip_o registered request pulses; rectified_o registered rectified value.
module aplic_gw_slice
   import aplic_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_src_i,
   input  sm_e  sm_i,
   input  logic ip_i,
   output logic set_ip_o,
   output logic clr_ip_o,
   output logic rectified_o
);

   logic src_s;

`ifdef AIA_GW_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= irq_src_i;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = irq_src_i;
`endif

   logic rect_d, rect_q;
   logic set_d, set_q;
   logic clr_d, clr_q;
   sm_e  mode_q;
   logic mode_chg;

   // rect_q doubles as the previous-rectified value for edge detection.
   // On a mode change it is simply reloaded with the new rect and no request
   // is issued, so reconfiguration (and the first cycle after reset, since
   // mode_q resets to INACTIVE) never produces a spurious edge.
   always_comb begin
      rect_d   = rectify(sm_i, src_s);
      mode_chg = (sm_i != mode_q);
      set_d    = 1'b0;
      clr_d    = 1'b0;
      if (!mode_chg) begin
         if (is_edge(sm_i)) begin
            set_d = rect_d & ~rect_q;
         end else if (is_level(sm_i)) begin
            set_d = rect_d & ~ip_i;
            clr_d = ~rect_d & ip_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rect_q <= 1'b0;
         set_q  <= 1'b0;
         clr_q  <= 1'b0;
         mode_q <= INACTIVE;
      end else begin
         rect_q <= rect_d;
         set_q  <= set_d;
         clr_q  <= clr_d;
         mode_q <= sm_i;
      end
   end

   assign set_ip_o    = set_q;
   assign clr_ip_o    = clr_q;
   assign rectified_o = rect_q;

endmodule

// File: rtl/aplic_gateway.sv
// APLIC per-source gateway: rectifies NR_SRC sources and issues set/clear-pending pulses.
// Latency: 1 cycle (3 cycles when AIA_GW_SYNC_EN is defined, adding input synchronizers).
// Backpressure: none; sources are independent and all may be active every cycle.
// Ports: clk_i, rst_ni (async, active low); bus (aplic_gateway_if.slave) carrying
//        irq_src_i, sm_i, ip_i in and set_ip_o, clr_ip_o, rectified_o out.
module aplic_gateway
   import aplic_pkg::*;
#(
   parameter int NR_SRC = 32
)(
   input  logic            clk_i,
   input  logic            rst_ni,
   aplic_gateway_if.slave  bus
);

   logic [NR_SRC-1:0] set_v;
   logic [NR_SRC-1:0] clr_v;
   logic [NR_SRC-1:0] rect_v;

   // Vector bit g is interrupt source g+1.
   for (genvar g = 0; g < NR_SRC; g++) begin : g_src
      aplic_gw_slice u_slice (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .irq_src_i   (bus.irq_src_i[g]),
         .sm_i        (sm_e'(bus.sm_i[SM_W*g +: SM_W])),
         .ip_i        (bus.ip_i[g]),
         .set_ip_o    (set_v[g]),
         .clr_ip_o    (clr_v[g]),
         .rectified_o (rect_v[g])
      );
   end

   assign bus.set_ip_o    = set_v;
   assign bus.clr_ip_o    = clr_v;
   assign bus.rectified_o = rect_v;

endmodule
